// File: rtl/wb_mem_arbiter_pkg.sv
// Shared encodings for the titan Wishbone arbiter: FSM state codes and master ids.
package titan_bus_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  localparam logic MID_I = 1'b0;
  localparam logic MID_D = 1'b1;

endpackage

// File: rtl/wb_mem_arbiter_if.sv
// Bundle of the i-master, d-master and slave Wishbone signals around the arbiter.
interface wb_mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [AW-1:0]   iaddr_i;
  logic            icyc_i;
  logic            istb_i;
  logic [DW-1:0]   idat_o;
  logic            iack_o;
  logic            ierr_o;

  logic [AW-1:0]   daddr_i;
  logic [DW-1:0]   ddat_i;
  logic [DW/8-1:0] dsel_i;
  logic            dwe_i;
  logic            dcyc_i;
  logic            dstb_i;
  logic [DW-1:0]   ddat_o;
  logic            dack_o;
  logic            derr_o;

  logic [AW-1:0]   saddr_o;
  logic [DW-1:0]   sdat_o;
  logic [DW/8-1:0] ssel_o;
  logic            swe_o;
  logic            scyc_o;
  logic            sstb_o;
  logic [DW-1:0]   sdat_i;
  logic            sack_i;
  logic            serr_i;

  // Arbiter side: takes master requests and slave responses.
  modport slave (
    input  iaddr_i, icyc_i, istb_i,
    output idat_o, iack_o, ierr_o,
    input  daddr_i, ddat_i, dsel_i, dwe_i, dcyc_i, dstb_i,
    output ddat_o, dack_o, derr_o,
    output saddr_o, sdat_o, ssel_o, swe_o, scyc_o, sstb_o,
    input  sdat_i, sack_i, serr_i
  );

  // Environment side: the two masters plus the shared slave.
  modport master (
    output iaddr_i, icyc_i, istb_i,
    input  idat_o, iack_o, ierr_o,
    output daddr_i, ddat_i, dsel_i, dwe_i, dcyc_i, dstb_i,
    input  ddat_o, dack_o, derr_o,
    input  saddr_o, sdat_o, ssel_o, swe_o, scyc_o, sstb_o,
    output sdat_i, sack_i, serr_i
  );

endinterface

// File: rtl/wb_mem_arbiter_watchdog.sv
// Bus watchdog: counts stalled strobe cycles and flags a timeout when the limit is hit.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  input  logic err,
  output logic timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // A slave response in the limit cycle takes precedence over the forced error.
  assign timeout = stb && !ack && !err && (count == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!stb || ack || err || timeout) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master/one-slave Wishbone classic arbiter: round-robin, grant locked per cyc, watchdog.
module wb_mem_arbiter
  import titan_bus_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  wb_mem_arbiter_if.slave   bus
);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            last;
  logic            gnt_i;
  logic            gnt_d;
  logic [AW-1:0]   addr_mux;
  logic [DW-1:0]   wdat_mux;
  logic [DW/8-1:0] sel_mux;
  logic            we_mux;
  logic            cyc_mux;
  logic            stb_mux;
  logic            timeout;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.icyc_i && bus.dcyc_i) begin
          state_nxt = (last == MID_I) ? GNT_D : GNT_I;
        end else if (bus.icyc_i) begin
          state_nxt = GNT_I;
        end else if (bus.dcyc_i) begin
          state_nxt = GNT_D;
        end
      end
      GNT_I:   if (!bus.icyc_i) state_nxt = IDLE;
      GNT_D:   if (!bus.dcyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      last  <= MID_I;
    end else begin
      state <= state_nxt;
      if (state == GNT_I && !bus.icyc_i) last <= MID_I;
      if (state == GNT_D && !bus.dcyc_i) last <= MID_D;
    end
  end

  assign gnt_i = (state == GNT_I);
  assign gnt_d = (state == GNT_D);

  always_comb begin
    addr_mux = '0;
    wdat_mux = '0;
    sel_mux  = '0;
    we_mux   = 1'b0;
    cyc_mux  = 1'b0;
    stb_mux  = 1'b0;
    if (gnt_i) begin
      addr_mux = bus.iaddr_i;
      sel_mux  = '1;
      cyc_mux  = bus.icyc_i;
      stb_mux  = bus.istb_i;
    end else if (gnt_d) begin
      addr_mux = bus.daddr_i;
      wdat_mux = bus.ddat_i;
      sel_mux  = bus.dsel_i;
      we_mux   = bus.dwe_i;
      cyc_mux  = bus.dcyc_i;
      stb_mux  = bus.dstb_i;
    end
  end

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stb     (stb_mux),
    .ack     (bus.sack_i),
    .err     (bus.serr_i),
    .timeout (timeout)
  );

  assign bus.saddr_o = addr_mux;
  assign bus.sdat_o  = wdat_mux;
  assign bus.ssel_o  = sel_mux;
  assign bus.swe_o   = we_mux;
  assign bus.scyc_o  = cyc_mux;
  assign bus.sstb_o  = stb_mux && !timeout;

  // Responses reach only the granted master; err dominates a simultaneous ack.
  assign bus.iack_o = gnt_i && bus.sack_i && !bus.serr_i;
  assign bus.ierr_o = gnt_i && (bus.serr_i || timeout);
  assign bus.dack_o = gnt_d && bus.sack_i && !bus.serr_i;
  assign bus.derr_o = gnt_d && (bus.serr_i || timeout);
  assign bus.idat_o = gnt_i ? bus.sdat_i : '0;
  assign bus.ddat_o = gnt_d ? bus.sdat_i : '0;

endmodule
